// File: rtl/spu_pkg.sv
// Shared types and constants for the SPU decode stage.
//   fmt_e  : instruction format code carried on out_fmt
//   IMM_SEL_* : select codes understood by imm_select
//   OP_*   : opcode values matched by the field decoder
//   dec_t  : decoded bundle stored in the decode-stage queue
package spu_pkg;

  typedef enum logic [2:0] {
    FMT_RR   = 3'd0,
    FMT_RRR  = 3'd1,
    FMT_RI7  = 3'd2,
    FMT_RI10 = 3'd3,
    FMT_RI16 = 3'd4,
    FMT_RI18 = 3'd5,
    FMT_ILL  = 3'd7
  } fmt_e;

  localparam logic [1:0] IMM_SEL_I7  = 2'b00;
  localparam logic [1:0] IMM_SEL_I10 = 2'b01;
  localparam logic [1:0] IMM_SEL_I16 = 2'b10;
  localparam logic [1:0] IMM_SEL_I18 = 2'b11;

  localparam logic [3:0]  OP_FMA  = 4'hE;
  localparam logic [6:0]  OP_ILA  = 7'h21;
  localparam logic [7:0]  OP_AI   = 8'h1C;
  localparam logic [8:0]  OP_IL   = 9'h081;
  localparam logic [10:0] OP_SHLI = 11'h07B;
  localparam logic [10:0] OP_A    = 11'h0C0;

  typedef struct packed {
    fmt_e       fmt;
    logic [1:0] imm_sel;
    logic       uses_imm;
    logic [6:0] ra;
    logic [6:0] rb;
    logic [6:0] rc;
    logic [6:0] rt;
    logic       rt_we;
    logic       illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/spu_field_decode.sv
// Pure combinational SPU instruction classifier.
//   instr : 32-bit instruction word
//   dec   : packed dec_t bundle (format, imm select, register fields, flags)
// Opcodes are tried from the shortest opcode field to the longest; the first
// hit wins. Register fields not used by the matched format are forced to 0.
module spu_field_decode
  import spu_pkg::*;
(
  input  logic [31:0]      instr,
  output logic [DEC_W-1:0] dec
);

  dec_t d;

  always_comb begin
    d          = '0;
    d.fmt      = FMT_ILL;
    d.illegal  = 1'b1;
    d.rt_we    = 1'b0;
    if (instr[3:0] == OP_FMA) begin
      d.fmt = FMT_RRR;
      d.rt  = instr[10:4];
      d.rb  = instr[17:11];
      d.ra  = instr[24:18];
      d.rc  = instr[31:25];
    end else if (instr[6:0] == OP_ILA) begin
      d.fmt      = FMT_RI18;
      d.imm_sel  = IMM_SEL_I18;
      d.uses_imm = 1'b1;
      d.rt       = instr[31:25];
    end else if (instr[7:0] == OP_AI) begin
      d.fmt      = FMT_RI10;
      d.imm_sel  = IMM_SEL_I10;
      d.uses_imm = 1'b1;
      d.ra       = instr[24:18];
      d.rt       = instr[31:25];
    end else if (instr[8:0] == OP_IL) begin
      d.fmt      = FMT_RI16;
      d.imm_sel  = IMM_SEL_I16;
      d.uses_imm = 1'b1;
      d.rt       = instr[31:25];
    end else if (instr[10:0] == OP_A) begin
      d.fmt = FMT_RR;
      d.rb  = instr[17:11];
      d.ra  = instr[24:18];
      d.rt  = instr[31:25];
    end else if (instr[10:0] == OP_SHLI) begin
      // Bits [17:11] hold i7 here, so rb stays 0.
      d.fmt      = FMT_RI7;
      d.imm_sel  = IMM_SEL_I7;
      d.uses_imm = 1'b1;
      d.ra       = instr[24:18];
      d.rt       = instr[31:25];
    end
    if (d.fmt != FMT_ILL) begin
      d.illegal = 1'b0;
      d.rt_we   = 1'b1;
    end
  end

  assign dec = d;

endmodule

// File: rtl/spu_decode_stage.sv
// SPU instruction decode stage feeding imm_select.
// Decodes the incoming word combinationally and stores the decoded bundle in
// a 2-entry elastic queue; out_* always come from queue registers.
//   clk, rst (sync, active-high), flush (sync queue clear)
//   in_valid/in_ready/in_instr/in_pc     : upstream handshake + payload
//   out_valid/out_ready                  : downstream handshake
//   out_instr/out_pc/out_fmt/out_imm_sel/out_uses_imm/out_ra/rb/rc/rt/
//   out_rt_we/out_illegal                : head entry, all 0 when empty
//   illegal_sticky : set when an illegal entry is popped, cleared by rst
//   dec_count      : number of popped entries (wraps)
module spu_decode_stage
  import spu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [2:0]       out_fmt,
  output logic [1:0]       out_imm_sel,
  output logic             out_uses_imm,
  output logic [6:0]       out_ra,
  output logic [6:0]       out_rb,
  output logic [6:0]       out_rc,
  output logic [6:0]       out_rt,
  output logic             out_rt_we,
  output logic             out_illegal,
  output logic             illegal_sticky,
  output logic [CNT_W-1:0] dec_count
);

  localparam int ENT_W = 32 + PC_W + DEC_W;

  // ---- stage p0: combinational decode of the incoming word ----
  logic [DEC_W-1:0] dec_p0;
  logic [ENT_W-1:0] ent_p0;

  spu_field_decode u_dec (
    .instr (in_instr),
    .dec   (dec_p0)
  );

  assign ent_p0 = {in_instr, in_pc, dec_p0};

  // ---- stage p1: 2-entry queue, ent0_p1 is the head ----
  logic [ENT_W-1:0] ent0_p1, ent1_p1, head_p1;
  logic [1:0]       cnt_p1;
  logic             vld_p1, push, pop, load_head;
  dec_t             head_dec;

  assign vld_p1   = (cnt_p1 != 2'd0);
  assign in_ready = !rst && !flush && (cnt_p1 != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = vld_p1 && out_ready;
  // New word goes straight to the head when the queue is, or is about to be, empty.
  assign load_head = push && ((cnt_p1 == 2'd0) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1         <= 2'd0;
      illegal_sticky <= 1'b0;
      dec_count      <= '0;
    end else begin
      if (pop) begin
        dec_count <= dec_count + 1'b1;
        if (head_dec.illegal) illegal_sticky <= 1'b1;
      end
      if (flush) cnt_p1 <= 2'd0;
      else       cnt_p1 <= cnt_p1 + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (load_head)  ent0_p1 <= ent_p0;
    else if (pop)   ent0_p1 <= ent1_p1;
    if (push && !load_head) ent1_p1 <= ent_p0;
  end

  // Empty queue presents all-zero outputs regardless of stale entry contents.
  assign head_p1  = vld_p1 ? ent0_p1 : '0;
  assign head_dec = dec_t'(head_p1[DEC_W-1:0]);

  assign out_valid    = vld_p1;
  assign out_instr    = head_p1[ENT_W-1 -: 32];
  assign out_pc       = head_p1[DEC_W +: PC_W];
  assign out_fmt      = head_dec.fmt;
  assign out_imm_sel  = head_dec.imm_sel;
  assign out_uses_imm = head_dec.uses_imm;
  assign out_ra       = head_dec.ra;
  assign out_rb       = head_dec.rb;
  assign out_rc       = head_dec.rc;
  assign out_rt       = head_dec.rt;
  assign out_rt_we    = head_dec.rt_we;
  assign out_illegal  = head_dec.illegal;

endmodule

// File: tb/tb_spu_decode_stage.sv
// Scoreboard bench for spu_decode_stage: directed scenarios followed by a
// randomized phase, all checked against a format-rule reference model.
module tb_spu_decode_stage;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [2:0]  out_fmt;
  logic [1:0]  out_imm_sel;
  logic        out_uses_imm, out_rt_we, out_illegal, illegal_sticky;
  logic [6:0]  out_ra, out_rb, out_rc, out_rt;
  logic [15:0] dec_count;

  spu_decode_stage #(.PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_fmt(out_fmt), .out_imm_sel(out_imm_sel), .out_uses_imm(out_uses_imm),
    .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc), .out_rt(out_rt),
    .out_rt_we(out_rt_we), .out_illegal(out_illegal),
    .illegal_sticky(illegal_sticky), .dec_count(dec_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [1:0]  sel;
    logic        uses;
    logic [6:0]  ra, rb, rc, rt;
    logic        we, ill;
  } exp_t;

  int          n_cmp = 0, n_fail = 0;
  exp_t        sb[$];
  logic [15:0] exp_cnt = 0;
  logic        exp_sticky = 0;
  logic [31:0] pc_next = 32'h1000;

  // Reference: pick the format by opcode priority, then take the fields that
  // format defines.
  function automatic exp_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
    exp_t e = '0;
    int   f;
    e.instr = w;
    e.pc    = pc;
    if      (w[3:0]  == 4'hE)    f = 1;
    else if (w[6:0]  == 7'h21)   f = 5;
    else if (w[7:0]  == 8'h1C)   f = 3;
    else if (w[8:0]  == 9'h081)  f = 4;
    else if (w[10:0] == 11'h0C0) f = 0;
    else if (w[10:0] == 11'h07B) f = 2;
    else                         f = 7;
    e.fmt  = 3'(f);
    e.ill  = (f == 7);
    e.we   = (f != 7);
    e.uses = (f >= 2 && f <= 5);
    e.sel  = (f == 3) ? 2'd1 : (f == 4) ? 2'd2 : (f == 5) ? 2'd3 : 2'd0;
    e.rt   = (f == 1) ? w[10:4] : (f == 7) ? 7'd0 : w[31:25];
    e.ra   = (f <= 3) ? w[24:18] : 7'd0;
    e.rb   = (f <= 1) ? w[17:11] : 7'd0;
    e.rc   = (f == 1) ? w[31:25] : 7'd0;
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 6))
      0: r[3:0]  = 4'hE;
      1: r[6:0]  = 7'h21;
      2: r[7:0]  = 8'h1C;
      3: r[8:0]  = 9'h081;
      4: r[10:0] = 11'h0C0;
      5: r[10:0] = 11'h07B;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  task automatic chk_head(input exp_t e);
    exp_t a;
    a = {out_instr, out_pc, out_fmt, out_imm_sel, out_uses_imm,
         out_ra, out_rb, out_rc, out_rt, out_rt_we, out_illegal};
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL head: got %h want %h (t=%0t)", a, e, $time);
    end
  endtask

  // Monitor: samples mid-cycle, compares, then advances the model by the
  // handshakes that will take effect at the next rising edge.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = !rst && !flush && (sb.size() != 2);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
    chk("dec_count", {16'b0, dec_count}, {16'b0, exp_cnt});
    chk("illegal_sticky", {31'b0, illegal_sticky}, {31'b0, exp_sticky});
    if (sb.size() != 0) chk_head(sb[0]);
    else                chk_head('0);
    if (rst) begin
      sb.delete();
      exp_cnt    = 0;
      exp_sticky = 0;
    end else begin
      if (sb.size() != 0 && out_ready) begin
        if (sb[0].ill) exp_sticky = 1;
        exp_cnt++;
        void'(sb.pop_front());
      end
      if (flush) sb.delete();
      else if (in_valid && exp_rdy) sb.push_back(ref_dec(in_instr, in_pc));
    end
  end

  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] w);
    bit done = 0;
    in_valid = 1; in_instr = w; in_pc = pc_next;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      step();
    end
    in_valid = 0;
    pc_next += 4;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: word %h not accepted within 20 cycles", w);
    end
  endtask

  task automatic send_chk(input logic [31:0] w, input logic [2:0] f, input logic [1:0] s,
                          input logic [6:0] rc);
    send(w);
    @(negedge clk);
    chk("fmt", {29'b0, out_fmt}, {29'b0, f});
    chk("imm_sel", {30'b0, out_imm_sel}, {30'b0, s});
    chk("rc", {25'b0, out_rc}, {25'b0, rc});
    step();
  endtask

  initial begin
    logic [31:0] w;
    rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    // 1: reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rdy_after_rst", {31'b0, in_ready}, 32'd1);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_instr", out_instr, 32'd0);
    step(); step();

    // 2: RR add
    w = (32'd7 << 25) | (32'd5 << 18) | (32'd6 << 11) | 32'h0C0;
    send(w);
    @(negedge clk);
    chk("a_fmt", {29'b0, out_fmt}, 32'd0);
    chk("a_uses", {31'b0, out_uses_imm}, 32'd0);
    chk("a_ra", {25'b0, out_ra}, 32'd5);
    chk("a_rb", {25'b0, out_rb}, 32'd6);
    chk("a_rt", {25'b0, out_rt}, 32'd7);
    chk("a_we", {31'b0, out_rt_we}, 32'd1);
    step();
    out_ready = 1;
    step();

    // 3: one of each immediate format, plus FMA
    w = $urandom; w[10:0] = 11'h07B; send_chk(w, 3'd2, 2'b00, 7'd0);
    w = $urandom; w[7:0]  = 8'h1C;   send_chk(w, 3'd3, 2'b01, 7'd0);
    w = $urandom; w[8:0]  = 9'h081;  send_chk(w, 3'd4, 2'b10, 7'd0);
    w = $urandom; w[6:0]  = 7'h21;   send_chk(w, 3'd5, 2'b11, 7'd0);
    w = $urandom; w[3:0]  = 4'hE;    send_chk(w, 3'd1, 2'b00, w[31:25]);

    // reset with the queue holding entries
    out_ready = 0;
    send(rand_word()); send(rand_word());
    rst = 1; step(); step(); rst = 0;
    step();

    // 4: three pushes against a stalled consumer
    send(rand_word()); send(rand_word());
    w = rand_word();
    in_valid = 1; in_instr = w; in_pc = pc_next;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    step();
    out_ready = 1;
    send(w);
    repeat (5) step();
    @(negedge clk);
    chk("dec_count_3", {16'b0, dec_count}, 32'd3);
    step();

    // 5: flush a full queue while popping
    out_ready = 0;
    send(rand_word()); send(rand_word());
    flush = 1; out_ready = 1;
    step();
    flush = 0; out_ready = 0;
    @(negedge clk);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_count", {16'b0, dec_count}, 32'd4);
    step();

    // 6: illegal word
    send(32'h0000_000F);
    @(negedge clk);
    chk("ill_fmt", {29'b0, out_fmt}, 32'd7);
    chk("ill_flag", {31'b0, out_illegal}, 32'd1);
    chk("ill_we", {31'b0, out_rt_we}, 32'd0);
    chk("ill_sticky_pre", {31'b0, illegal_sticky}, 32'd0);
    step();
    out_ready = 1;
    step();
    send(rand_word());
    @(negedge clk);
    chk("ill_sticky_post", {31'b0, illegal_sticky}, 32'd1);
    step();
    rst = 1; step(); rst = 0;
    @(negedge clk);
    chk("sticky_cleared", {31'b0, illegal_sticky}, 32'd0);
    step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_word();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    in_valid = 0; flush = 0; rst = 0; out_ready = 1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
